// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing and test-pattern generator.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_mode       pattern select: 0 solid, 1 border checker, 2 colour bars, 3 external
//   i_ext_rgb    pixel data answering the fetch issued one pixel tick earlier
//   o_pix_req    fetch strobe, high on pixel ticks at active positions
//   o_pix_x/y    pixel position being fetched (raster counters)
//   o_rgb        output colour {R,G,B} 4 bits each
//   o_hs/o_vs    syncs with programmable polarity
//   o_de         active-video enable
//   o_sof        one-clk pulse while pixel (0,0) is presented
//   o_frame_cnt  completed-frame counter
//
// Pipeline: counters (stage 0) -> decode (stage 1) -> output registers (stage 2),
// every stage advancing only on the pixel tick, so outputs trail the counters
// by exactly two pixel ticks.
//
// state              | meaning
// r_x/r_y            | raster position of the pixel being fetched
// r_mode             | pattern in use for the current frame
// stage-1 registers  | decoded position one tick behind the counters
// stage-2 registers  | output pins, two ticks behind the counters
module video_timing_gen #(
  parameter int          H_ACTIVE = 960,
  parameter int          H_FP     = 44,
  parameter int          H_SYNC   = 22,
  parameter int          H_BP     = 74,
  parameter int          V_ACTIVE = 1080,
  parameter int          V_FP     = 4,
  parameter int          V_SYNC   = 5,
  parameter int          V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int          PIX_DIV  = 1,
  parameter int          BORDER_W = 8,
  parameter int          BORDER_H = 16,
  parameter logic [11:0] BG_RGB   = 12'h333
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_mode,
  input  logic [11:0] i_ext_rgb,
  output logic        o_pix_req,
  output logic [11:0] o_pix_x,
  output logic [11:0] o_pix_y,
  output logic [11:0] o_rgb,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_sof,
  output logic [7:0]  o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_L  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_L  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_W_L  = 12'(H_ACTIVE / 8);
  localparam logic [11:0] BRD_L    = 12'(BORDER_W);
  localparam logic [11:0] BRD_R    = 12'(H_ACTIVE - BORDER_W);
  localparam logic [11:0] BRD_T    = 12'(BORDER_H);
  localparam logic [11:0] BRD_B    = 12'(V_ACTIVE - BORDER_H);

  logic [DIV_W-1:0] r_div;
  logic [11:0]      r_x, r_y;
  logic [1:0]       r_mode;
  logic [7:0]       r_frame;
  logic [11:0]      r_x1, r_y1, r_seg;
  logic             r_act1, r_hs1, r_vs1;
  logic [2:0]       r_bar1;
  logic [11:0]      r_rgb;
  logic             r_hs, r_vs, r_de, r_sof;

  logic             w_pe;
  logic             w_in_hact;
  logic             w_act0;
  logic             w_border;
  logic [11:0]      w_rgb;

  assign w_pe      = (r_div == '0);
  assign w_in_hact = (r_x < H_ACT_L);
  assign w_act0    = w_in_hact && (r_y < V_ACT_L);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_div <= '0;
    else if (r_div == DIV_LAST) r_div <= '0;
    else                       r_div <= r_div + 1'b1;
  end

  // Raster counters; the mode latch and frame count share the last-pixel tick
  // so a new pattern always starts cleanly at (0,0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_mode  <= '0;
      r_frame <= '0;
    end else if (w_pe) begin
      if (r_x == H_LAST) begin
        r_x <= '0;
        if (r_y == V_LAST) begin
          r_y     <= '0;
          r_mode  <= i_mode;
          r_frame <= r_frame + 8'd1;
        end else begin
          r_y <= r_y + 12'd1;
        end
      end else begin
        r_x <= r_x + 12'd1;
      end
    end
  end

  // Stage 1. r_seg counts pixels already placed in the current bar, so the bar
  // index steps every H_ACTIVE/8 pixels without needing a divider.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x1   <= '0;
      r_y1   <= '0;
      r_act1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_bar1 <= '0;
      r_seg  <= '0;
    end else if (w_pe) begin
      r_x1   <= r_x;
      r_y1   <= r_y;
      r_act1 <= w_act0;
      r_hs1  <= (r_x >= HS_START) && (r_x < HS_END);
      r_vs1  <= (r_y >= VS_START) && (r_y < VS_END);
      if (r_x == '0) begin
        r_bar1 <= '0;
        r_seg  <= 12'd1;
      end else if (w_in_hact) begin
        if (r_seg == BAR_W_L) begin
          r_bar1 <= r_bar1 + 3'd1;
          r_seg  <= 12'd1;
        end else begin
          r_seg <= r_seg + 12'd1;
        end
      end
    end
  end

  assign w_border = (r_x1 < BRD_L) || (r_x1 >= BRD_R) ||
                    (r_y1 < BRD_T) || (r_y1 >= BRD_B);

  always_comb begin
    w_rgb = '0;
    if (r_act1) begin
      case (r_mode)
        2'd0: w_rgb = BG_RGB;
        2'd1: begin
          if (w_border)
            w_rgb = (r_x1[1] ^ r_y1[2] ^ r_frame[5]) ? 12'hFFF : 12'h000;
          else
            w_rgb = BG_RGB;
        end
        2'd2: w_rgb = {{4{r_bar1[2]}}, {4{r_bar1[1]}}, {4{r_bar1[0]}}};
        default: w_rgb = i_ext_rgb;
      endcase
    end
  end

  // Stage 2: output registers. sof is cleared every clk so it lasts one clk
  // even when the pixel tick is slower than the clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb <= '0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_de  <= 1'b0;
      r_sof <= 1'b0;
    end else begin
      r_sof <= 1'b0;
      if (w_pe) begin
        r_rgb <= w_rgb;
        r_hs  <= r_hs1 ? HS_POL : ~HS_POL;
        r_vs  <= r_vs1 ? VS_POL : ~VS_POL;
        r_de  <= r_act1;
        r_sof <= r_act1 && (r_x1 == '0) && (r_y1 == '0);
      end
    end
  end

  // The divider idles at zero in reset, so the strobe is masked there.
  assign o_pix_req   = w_pe && w_act0 && i_rst_n;
  assign o_pix_x     = r_x;
  assign o_pix_y     = r_y;
  assign o_rgb       = r_rgb;
  assign o_hs        = r_hs;
  assign o_vs        = r_vs;
  assign o_de        = r_de;
  assign o_sof       = r_sof;
  assign o_frame_cnt = r_frame;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int HA  = 16, HFP = 2, HSW = 2, HBP = 4;
  localparam int VA  = 8,  VFP = 1, VSW = 1, VBP = 2;
  localparam int BW  = 3,  BH  = 2;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] mode;
  logic [11:0] a_ext = '0, b_ext = '0;
  logic [11:0] a_pend = '0, b_pend = '0;

  logic a_pix_req, a_hs, a_vs, a_de, a_sof;
  logic [11:0] a_pix_x, a_pix_y, a_rgb;
  logic [7:0] a_frame_cnt;
  logic b_pix_req, b_hs, b_vs, b_de, b_sof;
  logic [11:0] b_pix_x, b_pix_y, b_rgb;
  logic [7:0] b_frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int m [2];
  logic [1:0] fmode [2][512];
  int pt, k, cnt_de, cnt_hs, cnt_req, cnt_sof;
  logic [11:0] bars [16];

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1),
    .BORDER_W(BW), .BORDER_H(BH), .BG_RGB(12'h333)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_ext_rgb(a_ext),
    .o_pix_req(a_pix_req), .o_pix_x(a_pix_x), .o_pix_y(a_pix_y),
    .o_rgb(a_rgb), .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_sof(a_sof),
    .o_frame_cnt(a_frame_cnt)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(3),
    .BORDER_W(BW), .BORDER_H(BH), .BG_RGB(12'h333)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_ext_rgb(b_ext),
    .o_pix_req(b_pix_req), .o_pix_x(b_pix_x), .o_pix_y(b_pix_y),
    .o_rgb(b_rgb), .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_sof(b_sof),
    .o_frame_cnt(b_frame_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: expected pins derived from the count of clock edges since
  // reset release. Counters hold pixel index t, outputs show pixel t-2.
  task automatic model_check(input int i, input int d, input bit hp, input bit vp,
                             input logic pr, input logic [11:0] px, input logic [11:0] py,
                             input logic [11:0] rgb, input logic hs, input logic vs,
                             input logic de, input logic sof, input logic [7:0] fc);
    int t, p, x, y, f, bar;
    logic [1:0] md;
    logic [11:0] e_rgb;
    logic e_de, e_hs, e_vs, e_sof, e_pr;
    string s;
    s = (i == 0) ? "A" : "B";
    if (!rst_n) begin
      check({s, ".rst_pix_req"}, pr, 0);
      check({s, ".rst_pix_x"}, px, 0);
      check({s, ".rst_pix_y"}, py, 0);
      check({s, ".rst_rgb"}, rgb, 0);
      check({s, ".rst_hs"}, hs, !hp);
      check({s, ".rst_vs"}, vs, !vp);
      check({s, ".rst_de"}, de, 0);
      check({s, ".rst_sof"}, sof, 0);
      check({s, ".rst_frame_cnt"}, fc, 0);
      return;
    end
    t = (m[i] == 0) ? 0 : (m[i] - 1) / d + 1;
    e_pr = (m[i] % d == 0) && ((t % HT) < HA) && (((t / HT) % VT) < VA);
    check({s, ".pix_req"}, pr, e_pr);
    check({s, ".pix_x"}, px, t % HT);
    check({s, ".pix_y"}, py, (t / HT) % VT);
    check({s, ".frame_cnt"}, fc, (t / FT) % 256);
    e_sof = (m[i] >= 1) && ((m[i] - 1) % d == 0) && (t >= 2) && ((t - 2) % FT == 0);
    check({s, ".sof"}, sof, e_sof);
    if (t < 2) begin
      e_de = 0; e_hs = !hp; e_vs = !vp; e_rgb = 0;
    end else begin
      p = t - 2;
      x = p % HT;
      y = (p / HT) % VT;
      f = p / FT;
      e_de = (x < HA) && (y < VA);
      e_hs = (x >= HA + HFP && x < HA + HFP + HSW) ? hp : !hp;
      e_vs = (y >= VA + VFP && y < VA + VFP + VSW) ? vp : !vp;
      md = fmode[i][f % 512];
      e_rgb = 12'h000;
      if (e_de) begin
        case (md)
          2'd0: e_rgb = 12'h333;
          2'd1: begin
            if (x < BW || x >= HA - BW || y < BH || y >= VA - BH)
              e_rgb = ((((x >> 1) ^ (y >> 2) ^ ((f % 256) >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
            else
              e_rgb = 12'h333;
          end
          2'd2: begin
            bar = x / (HA / 8);
            e_rgb = {((bar & 4) != 0) ? 4'hF : 4'h0, ((bar & 2) != 0) ? 4'hF : 4'h0,
                     ((bar & 1) != 0) ? 4'hF : 4'h0};
          end
          default: e_rgb = {4'(y), 8'(x)};
        endcase
      end
    end
    check({s, ".de"}, de, e_de);
    check({s, ".hs"}, hs, e_hs);
    check({s, ".vs"}, vs, e_vs);
    check({s, ".rgb"}, rgb, e_rgb);
  endtask

  // Edge counting and per-frame mode history for the model.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m[i] = 0;
      end else begin
        m[i] = m[i] + 1;
        if ((m[i] - 1) % ((i == 0) ? 1 : 3) == 0) begin
          pt = (m[i] - 1) / ((i == 0) ? 1 : 3);
          if (pt % FT == FT - 1) fmode[i][((pt + 1) / FT) % 512] = mode;
        end
      end
    end
  end

  always @(negedge clk) begin
    model_check(0, 1, 1'b1, 1'b1, a_pix_req, a_pix_x, a_pix_y, a_rgb, a_hs, a_vs,
                a_de, a_sof, a_frame_cnt);
    model_check(1, 3, 1'b0, 1'b0, b_pix_req, b_pix_x, b_pix_y, b_rgb, b_hs, b_vs,
                b_de, b_sof, b_frame_cnt);
  end

  // External pixel source: answers each fetch one pixel tick later.
  initial begin
    forever begin
      @(negedge clk);
      a_ext = a_pend;
      b_ext = b_pend;
      if (a_pix_req) a_pend = {a_pix_y[3:0], a_pix_x[7:0]};
      if (b_pix_req) b_pend = {b_pix_y[3:0], b_pix_x[7:0]};
    end
  end

  initial begin
    bars = '{12'h000, 12'h000, 12'h00F, 12'h00F, 12'h0F0, 12'h0F0, 12'h0FF, 12'h0FF,
             12'hF00, 12'hF00, 12'hF0F, 12'hF0F, 12'hFF0, 12'hFF0, 12'hFFF, 12'hFFF};
    for (int i = 0; i < 2; i++) begin
      m[i] = 0;
      for (int j = 0; j < 512; j++) fmode[i][j] = 2'd0;
    end
    rst_n = 1'b0;
    mode  = 2'd0;
    step(4);
    check("reset_a_rgb", a_rgb, 0);
    check("reset_a_hs", a_hs, 0);
    check("reset_b_hs", b_hs, 1);
    check("reset_b_vs", b_vs, 1);
    check("reset_a_pix_req", a_pix_req, 0);

    rst_n = 1'b1;
    step(1);
    check("first_de_early", a_de, 0);
    step(1);
    check("first_de", a_de, 1);
    check("first_rgb", a_rgb, 12'h333);
    check("first_sof", a_sof, 1);

    cnt_de = 0; cnt_hs = 0;
    repeat (24) begin
      cnt_de += int'(a_de);
      cnt_hs += int'(a_hs);
      step(1);
    end
    check("a_de_per_line", cnt_de, 16);
    check("a_hs_per_line", cnt_hs, 2);

    cnt_de = 0; cnt_hs = 0; cnt_req = 0;
    repeat (72) begin
      cnt_de  += int'(b_de);
      cnt_hs  += int'(!b_hs);
      cnt_req += int'(b_pix_req);
      step(1);
    end
    check("b_de_per_line", cnt_de, 48);
    check("b_hs_low_per_line", cnt_hs, 6);
    check("b_pix_req_per_line", cnt_req, 16);

    k = 0;
    while (!(a_frame_cnt == 8'd1 && a_pix_y == 12'd3) && k < 600) begin step(1); k++; end
    check("wait_frame1_y3", int'(k < 600), 1);
    mode = 2'd2;

    k = 0;
    while (!a_sof && k < 400) begin step(1); k++; end
    check("wait_frame2_sof", int'(k < 400), 1);
    check("frame2_cnt", a_frame_cnt, 2);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("bar_px%0d", i), a_rgb, bars[i]);
      step(1);
    end

    mode = 2'd3;
    cnt_sof = 0;
    repeat (288) begin
      cnt_sof += int'(a_sof);
      step(1);
    end
    check("sof_per_frame", cnt_sof, 1);

    k = 0;
    while (!a_de && k < 50) begin step(1); k++; end
    check("wait_ext_de", int'(k < 50), 1);
    check("ext_px_0_1", a_rgb, 12'h100);
    step(5);
    check("ext_px_5_1", a_rgb, 12'h105);

    mode = 2'd1;
    k = 0;
    while (!(a_sof && a_frame_cnt == 8'd31) && k < 10000) begin step(1); k++; end
    check("wait_frame31", int'(k < 10000), 1);
    check("checker_f31", a_rgb, 12'h000);
    k = 0;
    while (!(a_sof && a_frame_cnt == 8'd32) && k < 400) begin step(1); k++; end
    check("wait_frame32", int'(k < 400), 1);
    check("checker_f32", a_rgb, 12'hFFF);

    k = 0;
    while (!(a_pix_y == 12'd5 && a_pix_x == 12'd7) && k < 400) begin step(1); k++; end
    check("wait_y5_x7", int'(k < 400), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_a_de", a_de, 0);
    check("midrst_a_rgb", a_rgb, 0);
    check("midrst_a_frame_cnt", a_frame_cnt, 0);
    check("midrst_a_pix_x", a_pix_x, 0);
    check("midrst_a_hs", a_hs, 0);
    check("midrst_b_vs", b_vs, 1);
    step(3);
    rst_n = 1'b1;
    step(2);
    check("post_rst_sof", a_sof, 1);
    check("post_rst_rgb_mode0", a_rgb, 12'h333);
    check("post_rst_frame_cnt", a_frame_cnt, 0);
    step(1800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
